// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation datapath:
// operand width, one-hot FSM encodings and the fixed decrypt key/modulus.
package rsa_pkg;
  localparam int RSA_WIDTH = 16;

  typedef logic [4:0] state_t;

  localparam state_t S_IDLE = 5'b00001;
  localparam state_t S_PREP = 5'b00010;
  localparam state_t S_MUL  = 5'b00100;
  localparam state_t S_UPD  = 5'b01000;
  localparam state_t S_DONE = 5'b10000;

  localparam logic [15:0] KD = 16'd11;
  localparam logic [15:0] N  = 16'd52961;
endpackage

// File: rtl/rsa_modmul_serial.sv
// Bit-serial modular multiplier: p = a*b mod n, one bit of b per cycle, MSB first.
// i_start loads the operands; o_done is high during the cycle whose edge completes the last step.
module rsa_modmul_serial
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_p,
  output logic             o_done
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  // Double-and-add with two conditional subtractions; p < n in and out, so WIDTH+2 bits never overflow.
  function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] p,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] n,
                                                input logic             bit_b);
    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] nn;
    nn = {2'b00, n};
    t  = {1'b0, p, 1'b0};
    if (t >= nn) t = t - nn;
    if (bit_b) t = t + {2'b00, a};
    if (t >= nn) t = t - nn;
    return t[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_p    <= '0;
      r_a    <= i_a;
      r_b    <= i_b;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_p   <= mod_step(r_p, r_a, i_n, r_b[WIDTH-1]);
      r_b   <= {r_b[WIDTH-2:0], 1'b0};
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST) r_busy <= 1'b0;
    end
  end

  assign o_p    = r_p;
  assign o_done = r_busy && (r_cnt == LAST);
endmodule

// File: rtl/rsa_modexp_core.sv
// Right-to-left square-and-multiply modular exponentiation, o_result = number^key mod n,
// with a fixed latency of 2 + KEY_BITS*(WIDTH+1) cycles from i_start to o_finished.
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int WIDTH    = RSA_WIDTH,
  parameter int KEY_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [WIDTH-1:0]    i_number,
  input  logic [KEY_BITS-1:0] i_key,
  input  logic [WIDTH-1:0]    i_n,
  output logic [WIDTH-1:0]    o_result,
  output logic                o_finished,
  output logic                o_busy
);
  localparam int BC_W = $clog2(KEY_BITS + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(KEY_BITS - 1);

  state_t              r_state;
  state_t              w_next;
  logic [WIDTH-1:0]    r_number;
  logic [WIDTH-1:0]    r_n;
  logic [KEY_BITS-1:0] r_key;
  logic [WIDTH-1:0]    r_base;
  logic [WIDTH-1:0]    r_acc;
  logic [BC_W-1:0]     r_bitcnt;
  logic [WIDTH-1:0]    r_result;
  logic                r_finished;

  logic [WIDTH-1:0]    w_base_red;
  logic [WIDTH-1:0]    w_base_nxt;
  logic [WIDTH-1:0]    w_acc_nxt;
  logic [WIDTH-1:0]    w_sq_p;
  logic [WIDTH-1:0]    w_pr_p;
  logic                w_sq_done;
  logic                w_pr_done;
  logic                w_mul_start;
  logic                w_last_bit;

  // n has its MSB set, so a single subtraction fully reduces any WIDTH-bit base.
  assign w_base_red  = (r_number >= r_n) ? (r_number - r_n) : r_number;
  // Multipliers are loaded on the PREP/UPD edge with the values base/acc take on that same edge.
  assign w_base_nxt  = (r_state == S_PREP) ? w_base_red : w_sq_p;
  assign w_acc_nxt   = (r_state == S_PREP) ? WIDTH'(1) : (r_key[0] ? w_pr_p : r_acc);
  assign w_mul_start = (r_state == S_PREP) || (r_state == S_UPD);
  assign w_last_bit  = (r_bitcnt == LAST_BIT);

  rsa_modmul_serial #(.WIDTH(WIDTH)) u_sq (
    .clk(clk), .rst(rst), .i_start(w_mul_start),
    .i_a(w_base_nxt), .i_b(w_base_nxt), .i_n(r_n),
    .o_p(w_sq_p), .o_done(w_sq_done)
  );

  rsa_modmul_serial #(.WIDTH(WIDTH)) u_pr (
    .clk(clk), .rst(rst), .i_start(w_mul_start),
    .i_a(w_base_nxt), .i_b(w_acc_nxt), .i_n(r_n),
    .o_p(w_pr_p), .o_done(w_pr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_PREP;
      S_PREP:  w_next = S_MUL;
      S_MUL:   if (w_sq_done && w_pr_done) w_next = S_UPD;
      S_UPD:   w_next = w_last_bit ? S_DONE : S_MUL;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (r_state != S_IDLE);
    o_result   = r_result;
    o_finished = r_finished;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_number   <= '0;
      r_n        <= '0;
      r_key      <= '0;
      r_base     <= '0;
      r_acc      <= '0;
      r_bitcnt   <= '0;
      r_result   <= '0;
      r_finished <= 1'b0;
    end else begin
      r_finished <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_number <= i_number;
            r_key    <= i_key;
            r_n      <= i_n;
          end
        end
        S_PREP: begin
          r_base   <= w_base_nxt;
          r_acc    <= w_acc_nxt;
          r_bitcnt <= '0;
        end
        S_UPD: begin
          r_base   <= w_base_nxt;
          r_acc    <= w_acc_nxt;
          r_key    <= r_key >> 1;
          r_bitcnt <= r_bitcnt + 1'b1;
        end
        S_DONE: begin
          r_result   <= r_acc;
          r_finished <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed bench for rsa_modexp_core: hand-computed powers, latency, busy, re-start and reset abort.
module tb_rsa_modexp_core;
  import rsa_pkg::*;

  localparam int LAT = 274;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [15:0] i_number;
  logic [15:0] i_key;
  logic [15:0] i_n;
  logic [15:0] o_result;
  logic        o_finished;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;

  rsa_modexp_core dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_number(i_number), .i_key(i_key), .i_n(i_n),
    .o_result(o_result), .o_finished(o_finished), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one request; optionally re-pulse i_start with other operands after rep_at cycles.
  task automatic run_op(input logic [15:0] num, input logic [15:0] key, input logic [15:0] n,
                        input int rep_at, output logic [15:0] res, output int lat,
                        output bit busy_ok);
    @(negedge clk);
    i_number = num; i_key = key; i_n = n; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0; i_number = ~num; i_key = ~key; i_n = 16'h8001;
    lat = 0; busy_ok = 1'b1;
    while (!o_finished && lat < 400) begin
      if (lat == rep_at) begin
        i_start = 1'b1; i_number = 16'd7; i_key = 16'd3; i_n = 16'd40000;
      end else begin
        i_start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (!o_finished && !o_busy) busy_ok = 1'b0;
    end
    i_start = 1'b0;
    res = o_result;
  endtask

  task automatic do_case(input string tag, input logic [15:0] num, input logic [15:0] key,
                         input logic [15:0] n, input logic [15:0] exp, input int rep_at);
    logic [15:0] res;
    int          lat;
    bit          busy_ok;
    run_op(num, key, n, rep_at, res, lat, busy_ok);
    check_eq({tag, "_result"}, res, exp);
    check_eq({tag, "_latency"}, lat, LAT);
    check_eq({tag, "_busy_held"}, busy_ok, 1'b1);
    @(posedge clk); #1;
    check_eq({tag, "_fin_pulse"}, o_finished, 1'b0);
    check_eq({tag, "_idle_after"}, o_busy, 1'b0);
    check_eq({tag, "_result_held"}, o_result, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; i_start = 1'b0; i_number = '0; i_key = '0; i_n = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_result", o_result, 16'd0);
    check_eq("reset_finished", o_finished, 1'b0);
    check_eq("reset_busy", o_busy, 1'b0);
    rst = 1'b0;

    do_case("t1_3pow11",  16'd3,     KD,     N, 16'd18264, -1);
    do_case("t2_2pow11",  16'd2,     16'd11, N, 16'd2048,  -1);
    do_case("t2_key0",    16'd2,     16'd0,  N, 16'd1,     -1);
    do_case("t3_ffff",    16'd65535, 16'd1,  N, 16'd12574, -1);
    do_case("t3_npow5",   N,         16'd5,  N, 16'd0,     -1);
    do_case("t3_zero",    16'd0,     16'd7,  N, 16'd0,     -1);
    do_case("t4_m1sq",    16'd52960, 16'd2,  N, 16'd1,     -1);
    do_case("t5_restart", 16'd3,     16'd11, N, 16'd18264, 120);
    do_case("t5_late",    16'd2,     16'd11, N, 16'd2048,  273);

    // Abort an operation 100 cycles in; previous result is nonzero, so clearing is observable.
    @(negedge clk);
    i_number = 16'd3; i_key = 16'd11; i_n = N; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check_eq("t6_busy_before", o_busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("t6_rst_busy", o_busy, 1'b0);
    check_eq("t6_rst_result", o_result, 16'd0);
    check_eq("t6_rst_finished", o_finished, 1'b0);
    seen = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (o_finished) seen++;
    end
    check_eq("t6_no_pulse", seen, 0);
    do_case("t6_after", 16'd2, 16'd11, N, 16'd2048, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
